osd_ctm_trace_rx: RTL
=====================

// Module: osd_ctm_trace_rx
// PURPOSE
// - Receive side of the core trace (CTM) event protocol: consumes DII flits addressed to this
//   node, validates header, reassembles trace event packets into one parallel record per event.
// - Sits behind the debug ring egress on the host-side/trace-sink node; record feeds trace
//   storage or a compressor via valid/ready. Overflow packets are reported separately.
// PARAMETERS
// - ADDR_WIDTH  32  PC/NPC width; 32 or 64 only (AW=ADDR_WIDTH/16 words per address)
// PORTS
// - clk                  in   1   clock
// - rst                  in   1   reset, asynchronous, active-high
// - id                   in   16  own DII address; compared against packet word 0
// - debug_in             in   dii_flit  {valid,last,data[15:0]} flit stream from ring
// - debug_in_ready       out  1   flit accepted when debug_in.valid && debug_in_ready
// - trace_valid          out  1   event record valid
// - trace_ready          in   1   sink accepts record when trace_valid && trace_ready
// - trace_timestamp      out  32  event timestamp
// - trace_npc            out  ADDR_WIDTH  next/target PC
// - trace_pc             out  ADDR_WIDTH  PC of traced instruction
// - trace_mode           out  2   privilege mode
// - trace_is_ret/call/modechange  out  1 each  event flags
// - overflow_valid       out  1   one-cycle pulse: overflow packet received
// - overflow_count       out  16  lost-event count from last overflow packet (held)
// - drop_count           out  16  packets discarded (wrong dest/type/length), saturates 0xFFFF
// BEHAVIOUR
// - Reset: FSM=DEST, debug_in_ready=0 during reset then 1, trace_valid=0, overflow_valid=0,
//   all record fields, overflow_count, drop_count = 0. Reset mid-packet abandons it silently.
// - Packet: w0 dest, w1 src (ignored), w2 flags: type=[15:14], type_sub=[13:10]; payload follows.
// - Event packet: type=2'b10, type_sub=0; payload LSW-first: TS lo, TS hi, NPC (AW words),
//   PC (AW words), flag word {11'b0, modechange[4], call[3], ret[2], mode[1:0]}.
//   Payload length N=3+2*AW (7 for 32-bit, 11 for 64-bit); flit N carries last.
// - Overflow packet: type=2'b10, type_sub=5; exactly one payload word = lost count.
// - FSM: DEST -> (data==id ? SRC : DROP); SRC -> FLAGS; FLAGS -> event ? PAYLOAD :
//   overflow ? OVF : DROP; PAYLOAD counts words 0..N-1; OVF takes 1 word;
//   DROP consumes flits until last, then DEST. Any transition to DROP increments drop_count once.
// - Length rules: last on w0..w2, or before payload word N-1 -> packet discarded, drop_count+1,
//   next flit is new w0. Payload word N-1 without last -> DROP (discard), count+1.
//   Same rules for OVF with length 1.
// - Complete event: fields written into output register in the cycle the last flit is accepted;
//   trace_valid rises next cycle. Event->record latency 1 cycle after last flit.
// - Backpressure: single output register. While trace_valid && !trace_ready, debug_in_ready=0
//   only in PAYLOAD; header flits and other packets still drain. Parallel record staging register
//   allows next packet's payload collection; the final flit of the next event is held (ready=0)
//   until the output register is free. trace_valid falls the cycle after handshake unless
//   a new record loads in the same cycle (back-to-back records, no bubble).
// - Overflow: overflow_count updated and overflow_valid pulsed 1 cycle after last flit; independent
//   of trace backpressure; never stalls.
// - debug_in.valid=0 cycles: FSM holds; no timeouts.
// - drop_count saturating: stays 0xFFFF.
// TESTING
// - id=0x0010; event pkt 0010,0003,8000,5678,1234,1000,0000,2000,0000,0009 (last) ->
//   1 cyc later trace_valid, ts=0x12345678, npc=0x1000, pc=0x2000, mode=1, is_call=1.
// - dest=0x0011 event pkt -> no trace_valid, drop_count=1, next valid pkt decoded correctly.
// - Event pkt with last on payload word 4 -> discarded, drop_count+1; following flit parsed as w0.
// - Hold trace_ready=0, send two event pkts -> second pkt stalls on final flit (ready=0),
//   both records delivered in order once trace_ready=1, no loss.
// - Overflow pkt 0010,0003,9400,002A(last) -> overflow_valid pulse, overflow_count=0x002A,
//   while a pending trace record is back-pressured.
// - Assert rst mid-payload -> all outputs 0 immediately; next full pkt decodes correctly.

Source files
------------

// File: rtl/osd_ctm_trace_rx_if.sv
// DII flit stream (valid/last/data) with its ready back-channel.
// The master drives flits and the slave returns ready.
interface osd_ctm_trace_rx_if;
    logic        valid;
    logic        last;
    logic [15:0] data;
    logic        ready;

    modport master (output valid, output last, output data, input ready);
    modport slave  (input valid, input last, input data, output ready);
endinterface

// File: rtl/osd_ctm_trace_rx.sv
// CTM trace receiver: parses DII packets addressed to this node and rebuilds one parallel
// record per trace event; overflow packets are reported separately; bad packets are counted.
module osd_ctm_trace_rx #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           id,
    osd_ctm_trace_rx_if.slave     debug_in,
    output logic                  trace_valid,
    input  logic                  trace_ready,
    output logic [31:0]           trace_timestamp,
    output logic [ADDR_WIDTH-1:0] trace_npc,
    output logic [ADDR_WIDTH-1:0] trace_pc,
    output logic [1:0]            trace_mode,
    output logic                  trace_is_ret,
    output logic                  trace_is_call,
    output logic                  trace_is_modechange,
    output logic                  overflow_valid,
    output logic [15:0]           overflow_count,
    output logic [15:0]           drop_count
);
    localparam int AW = ADDR_WIDTH / 16;
    localparam int N  = 3 + 2 * AW;
    localparam logic [3:0] LAST_IDX = 4'(N - 1);

    localparam logic [2:0] S_DEST    = 3'd0;
    localparam logic [2:0] S_SRC     = 3'd1;
    localparam logic [2:0] S_FLAGS   = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_OVF     = 3'd4;
    localparam logic [2:0] S_DROP    = 3'd5;

    logic [2:0]            state_reg, state_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic [15:0]           stage_reg [N-1];
    logic [ADDR_WIDTH-1:0] npc_stage, pc_stage;
    logic                  out_free, stall, fire;
    logic                  is_event, is_ovf;
    logic                  drop_inc, rec_load, ovf_load;

    // Only the flag word of an event waits for the output register; everything else drains.
    assign out_free       = !trace_valid || trace_ready;
    assign stall          = (state_reg == S_PAYLOAD) && (cnt_reg == LAST_IDX) && !out_free;
    assign debug_in.ready = !rst && !stall;
    assign fire           = debug_in.valid && debug_in.ready;

    assign is_event = (debug_in.data[15:14] == 2'b10) && (debug_in.data[13:10] == 4'd0);
    assign is_ovf   = (debug_in.data[15:14] == 2'b10) && (debug_in.data[13:10] == 4'd5);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        drop_inc   = 1'b0;
        rec_load   = 1'b0;
        ovf_load   = 1'b0;
        if (fire) begin
            case (state_reg)
                S_DEST: begin
                    if (debug_in.data != id || debug_in.last) begin
                        drop_inc   = 1'b1;
                        state_next = debug_in.last ? S_DEST : S_DROP;
                    end else begin
                        state_next = S_SRC;
                    end
                end
                S_SRC: begin
                    drop_inc   = debug_in.last;
                    state_next = debug_in.last ? S_DEST : S_FLAGS;
                end
                S_FLAGS: begin
                    cnt_next = 4'd0;
                    if (debug_in.last) begin
                        drop_inc   = 1'b1;
                        state_next = S_DEST;
                    end else if (is_event) begin
                        state_next = S_PAYLOAD;
                    end else if (is_ovf) begin
                        state_next = S_OVF;
                    end else begin
                        drop_inc   = 1'b1;
                        state_next = S_DROP;
                    end
                end
                S_PAYLOAD: begin
                    if (cnt_reg == LAST_IDX) begin
                        rec_load   = debug_in.last;
                        drop_inc   = !debug_in.last;
                        state_next = debug_in.last ? S_DEST : S_DROP;
                    end else if (debug_in.last) begin
                        drop_inc   = 1'b1;
                        state_next = S_DEST;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
                S_OVF: begin
                    ovf_load   = debug_in.last;
                    drop_inc   = !debug_in.last;
                    state_next = debug_in.last ? S_DEST : S_DROP;
                end
                S_DROP: begin
                    if (debug_in.last) state_next = S_DEST;
                end
                default: state_next = S_DEST;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_DEST;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Staging holds every payload word except the flag word, which goes straight to the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N - 1; i++) stage_reg[i] <= 16'd0;
        end else if (fire && state_reg == S_PAYLOAD) begin
            for (int i = 0; i < N - 1; i++) begin
                if (cnt_reg == 4'(i)) stage_reg[i] <= debug_in.data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < AW; gi++) begin : g_addr
            assign npc_stage[gi*16 +: 16] = stage_reg[2 + gi];
            assign pc_stage[gi*16 +: 16]  = stage_reg[2 + AW + gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trace_valid         <= 1'b0;
            trace_timestamp     <= 32'd0;
            trace_npc           <= '0;
            trace_pc            <= '0;
            trace_mode          <= 2'd0;
            trace_is_ret        <= 1'b0;
            trace_is_call       <= 1'b0;
            trace_is_modechange <= 1'b0;
        end else begin
            if (rec_load) begin
                trace_valid         <= 1'b1;
                trace_timestamp     <= {stage_reg[1], stage_reg[0]};
                trace_npc           <= npc_stage;
                trace_pc            <= pc_stage;
                trace_mode          <= debug_in.data[1:0];
                trace_is_ret        <= debug_in.data[2];
                trace_is_call       <= debug_in.data[3];
                trace_is_modechange <= debug_in.data[4];
            end else if (trace_ready) begin
                trace_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_valid <= 1'b0;
            overflow_count <= 16'd0;
            drop_count     <= 16'd0;
        end else begin
            overflow_valid <= ovf_load;
            if (ovf_load) overflow_count <= debug_in.data;
            if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end
endmodule
